// File: rtl/branch_pkg.sv
// Types and constants shared by branch resolution, the tournament predictor and fetch.
package branch_pkg;

  localparam int unsigned PC_W = 15;

  typedef enum logic {
    IDLE    = 1'b0,
    RECOVER = 1'b1
  } resolve_state_t;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
  } redirect_t;

endpackage

// File: rtl/branch_stats.sv
// Saturating retired-branch and mispredict counters for branch_resolve.
module branch_stats #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mispredict,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (en && (stat_branches != '1))
        stat_branches <= stat_branches + CNT_W'(1);
      if (mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_resolve.sv
// Carries the F-stage prediction to E, resolves it against the actual outcome and
// drives predictor training plus flush/redirect. Optional counters: BRANCH_STATS_EN.
module branch_resolve #(
  parameter int unsigned PC_W  = branch_pkg::PC_W,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallD,
  input  logic             StallE,
  input  logic             predict_f,
  input  logic             is_branch_d,
  input  logic             taken_e,
  input  logic [PC_W-1:0]  target_e,
  input  logic [PC_W-1:0]  PCE,
  output logic             en,
  output logic             result,
  output logic             predict_e,
  output logic             mispredict,
  output logic             flush_d,
  output logic             flush_e,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  import branch_pkg::*;

  resolve_state_t  state, state_next;
  logic            pred_d;
  logic            pred_e;
  logic            br_e;
  logic [PC_W-1:0] pce_inc;

  assign pce_inc = PCE + PC_W'(1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst || flush_d)
      pred_d <= 1'b0;
    else if (!StallD)
      pred_d <= predict_f;
  end

  // The slot entering E from RECOVER or during a flush is a squashed one.
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_e <= 1'b0;
      br_e   <= 1'b0;
    end else if (!StallE) begin
      pred_e <= pred_d;
      br_e   <= is_branch_d & ~flush_d & (state == IDLE);
    end
  end

  // en fires only on the advancing cycle, so a stalled branch trains exactly once.
  always_comb begin
    en             = 1'b0;
    mispredict     = 1'b0;
    flush_d        = 1'b0;
    flush_e        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = pce_inc;
    state_next     = state;
    case (state)
      IDLE: begin
        en             = br_e & ~StallE & ~rst;
        mispredict     = en & (pred_e != taken_e);
        flush_d        = mispredict;
        flush_e        = mispredict;
        redirect_valid = mispredict;
        if (mispredict && taken_e)
          redirect_pc = target_e;
        if (mispredict)
          state_next = RECOVER;
      end
      RECOVER: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign result    = taken_e;
  assign predict_e = pred_e & ~rst;

`ifdef BRANCH_STATS_EN
  branch_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk              (clk),
    .rst              (rst),
    .en               (en),
    .mispredict       (mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed vector bench for branch_resolve: one table row per clock cycle.
module tb_branch_resolve;

  localparam int unsigned PC_W  = 15;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst, StallD, StallE, predict_f, is_branch_d, taken_e;
  logic [PC_W-1:0]  target_e, PCE;
  logic             en, result, predict_e, mispredict, flush_d, flush_e, redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] stat_branches, stat_mispredicts;

  always #5 clk = ~clk;

  branch_resolve #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .StallD(StallD), .StallE(StallE),
    .predict_f(predict_f), .is_branch_d(is_branch_d), .taken_e(taken_e),
    .target_e(target_e), .PCE(PCE), .en(en), .result(result),
    .predict_e(predict_e), .mispredict(mispredict), .flush_d(flush_d),
    .flush_e(flush_e), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  typedef struct {
    logic            rst, sd, se, pf, bd, tk;
    logic [PC_W-1:0] tgt, pce;
    logic            x_en, x_mp, x_pe;
    logic [PC_W-1:0] x_rpc;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   row   = 0;
  int   exp_br = 0;
  int   exp_mp = 0;

  function automatic vec_t mk(logic r, logic sd, logic se, logic pf, logic bd, logic tk,
                              logic [PC_W-1:0] tgt, logic [PC_W-1:0] pce,
                              logic xen, logic xmp, logic xpe, logic [PC_W-1:0] xrpc);
    vec_t v;
    v.rst = r; v.sd = sd; v.se = se; v.pf = pf; v.bd = bd; v.tk = tk;
    v.tgt = tgt; v.pce = pce;
    v.x_en = xen; v.x_mp = xmp; v.x_pe = xpe; v.x_rpc = xrpc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL row %0d %s: got %0h expected %0h", row, name, got, exp);
    end
  endtask

  // Apply one row just after a posedge, check mid-cycle, then clock it in.
  task automatic run(input vec_t v);
    logic [CNT_W-1:0] xb, xm;
    rst = v.rst; StallD = v.sd; StallE = v.se; predict_f = v.pf;
    is_branch_d = v.bd; taken_e = v.tk; target_e = v.tgt; PCE = v.pce;
    #2;
    chk("en",             {31'd0, en},             {31'd0, v.x_en});
    chk("result",         {31'd0, result},         {31'd0, v.tk});
    chk("predict_e",      {31'd0, predict_e},      {31'd0, v.x_pe});
    chk("mispredict",     {31'd0, mispredict},     {31'd0, v.x_mp});
    chk("flush_d",        {31'd0, flush_d},        {31'd0, v.x_mp});
    chk("flush_e",        {31'd0, flush_e},        {31'd0, v.x_mp});
    chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, v.x_mp});
    chk("redirect_pc",    {17'd0, redirect_pc},    {17'd0, v.x_rpc});
    if (!v.rst) begin
`ifdef BRANCH_STATS_EN
      xb = CNT_W'(exp_br); xm = CNT_W'(exp_mp);
`else
      xb = '0; xm = '0;
`endif
      chk("stat_branches",    stat_branches,    xb);
      chk("stat_mispredicts", stat_mispredicts, xm);
    end
    @(posedge clk);
    #1;
    if (v.rst) begin
      exp_br = 0; exp_mp = 0;
    end else begin
      if (v.x_en) exp_br++;
      if (v.x_mp) exp_mp++;
    end
    row++;
  endtask

  localparam logic [PC_W-1:0] P   = 15'h0100;
  localparam logic [PC_W-1:0] P1  = 15'h0101;
  localparam logic [PC_W-1:0] T   = 15'h0200;

  initial begin
    rst = 1'b1; StallD = 1'b0; StallE = 1'b0; predict_f = 1'b0;
    is_branch_d = 1'b0; taken_e = 1'b0; target_e = '0; PCE = '0;
    #1;
    //                 rst sd se pf bd tk  tgt       pce       en mp pe rpc
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, T,        P,        0, 0, 0, P1));
    // correctly predicted taken branch
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, T,        P,        0, 0, 0, P1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, T,        P,        0, 0, 0, P1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, T,        P,        1, 0, 1, P1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, T,        P,        0, 0, 0, P1));
    // mispredict not-taken, then RECOVER with a D branch that must be dropped
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, T,        P,        0, 0, 0, P1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, T,        P,        0, 0, 0, P1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, T,        P,        1, 1, 1, P1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, T,        P,        0, 0, 0, P1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, T,        P,        0, 0, 0, P1));
    // mispredict taken to target
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, T,        P,        0, 0, 0, P1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 15'h1234, P,        1, 1, 0, 15'h1234));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, T,        P,        0, 0, 0, P1));
    // mispredict not-taken at PCE all-ones wraps to 0
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, T,        P,        0, 0, 0, P1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, T,        P,        0, 0, 0, P1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, T,        15'h7FFF, 1, 1, 1, 15'h0000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, T,        P,        0, 0, 0, P1));
    // mispredict while a branch is in D: the D branch is squashed
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, T,        P,        0, 0, 0, P1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, T,        P,        0, 0, 0, P1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, T,        P,        1, 1, 1, P1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, T,        P,        0, 0, 0, P1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, T,        P,        0, 0, 0, P1));
    // correctly predicted not-taken branch
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, T,        P,        0, 0, 0, P1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, T,        P,        1, 0, 0, P1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, T,        P,        0, 0, 0, P1));

    foreach (tbl[i]) run(tbl[i]);

    // Stalled mispredicting branch: silent for 3 cycles, resolves once on release.
    run(mk(0, 0, 0, 1, 0, 0, T, P, 0, 0, 0, P1));
    run(mk(0, 0, 0, 0, 1, 0, T, P, 0, 0, 0, P1));
    for (int k = 0; k < 3; k++)
      run(mk(0, 0, 1, 0, 0, 0, T, P, 0, 0, 1, P1));
    run(mk(0, 0, 0, 0, 0, 0, T, P, 1, 1, 1, P1));
    run(mk(0, 0, 0, 0, 0, 0, T, P, 0, 0, 0, P1));
    run(mk(0, 0, 0, 0, 0, 0, T, P, 0, 0, 0, P1));

    // Reset while in RECOVER, then a branch trains normally.
    run(mk(0, 0, 0, 1, 0, 0, T, P, 0, 0, 0, P1));
    run(mk(0, 0, 0, 0, 1, 0, T, P, 0, 0, 0, P1));
    run(mk(0, 0, 0, 0, 0, 0, T, P, 1, 1, 1, P1));
    run(mk(1, 0, 0, 1, 1, 0, T, P, 0, 0, 0, P1));
    run(mk(0, 0, 0, 1, 0, 0, T, P, 0, 0, 0, P1));
    run(mk(0, 0, 0, 0, 1, 0, T, P, 0, 0, 0, P1));
    run(mk(0, 0, 0, 0, 0, 1, T, P, 1, 0, 1, P1));
    run(mk(0, 0, 0, 0, 0, 0, T, P, 0, 0, 0, P1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
Execute-stage consumer of the tournament predictor's `predict` bit. It carries the prediction from F through D to E alongside the branch, and compares it with the actual outcome in E. It drives the predictor's training inputs (`en`, `result`), plus flush and redirect controls to the fetch and pipeline-control logic. It guarantees exactly one predictor update per retired conditional branch, so global history stays consistent under stalls and flushes.

Parameters:
PC_W, 15, PC width in words; must match predictor PCF/PCE width.
CNT_W, 32, width of statistics counters (used only with the optional feature).

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  synchronous, active-high reset.
StallD  in  1  hold the D-stage registers.
StallE  in  1  hold the E-stage registers.
predict_f  in  1  prediction for the instruction in F (predictor `predict`).
is_branch_d  in  1  instruction in D is a conditional branch.
taken_e  in  1  actual branch outcome in E; meaningful only when a branch is in E.
target_e  in  PC_W  branch target computed in E.
PCE  in  PC_W  PC of the instruction in E.
en  out  1  predictor update strobe.
result  out  1  actual outcome to the predictor (equals taken_e).
predict_e  out  1  prediction carried to E.
mispredict  out  1  prediction differs from the outcome for a valid E branch.
flush_d  out  1  squash the D-stage instruction.
flush_e  out  1  squash the instruction entering E next cycle.
redirect_valid  out  1  fetch must load redirect_pc.
redirect_pc  out  PC_W  corrected fetch PC.
stat_branches  out  CNT_W  retired branch count.
stat_mispredicts  out  CNT_W  mispredict count.

Behaviour:
- Pipeline registers:
  - predD <= predict_f when ~StallD.
  - On a D advance (~StallE), predE <= predD and brE <= is_branch_d & ~flush_d.
  - flush_d has priority over StallD: predD is cleared whenever flush_d is asserted.
  - When StallE is high, brE and predE hold.
- en = brE & ~StallE & (state == IDLE). It is asserted for exactly one cycle per branch, even if the branch sits in E for several stalled cycles.
- result = taken_e. predict_e = predE.
- mispredict = en & (predE != taken_e). The signal is combinational in the same cycle as en.
- redirect_valid = flush_d = flush_e = mispredict.
- redirect_pc = taken_e ? target_e : PCE + 1, computed modulo 2^PC_W, so all-ones wraps to 0. When redirect_valid is 0, redirect_pc is don't-care but driven as PCE + 1.
- FSM resolve_state_t has two states, IDLE and RECOVER:
  - IDLE -> RECOVER on mispredict.
  - RECOVER -> IDLE unconditionally after one cycle.
  - In RECOVER, en, mispredict and all flush/redirect outputs are forced to 0. This prevents a squashed slot from being trained or redirected.
  - In RECOVER, brE is forced to 0 on the next advance.
- Simultaneous events:
  - A mispredict while is_branch_d = 1: the D branch is squashed (brE <= 0) and is never trained.
  - StallE = 1 with a branch in E: no outputs assert until the cycle StallE drops.
- Reset:
  - rst forces state = IDLE and clears brE, predE, predD and the counters.
  - All outputs are 0 in the reset cycle, except redirect_pc = PCE + 1 and result = taken_e.
  - Reset during RECOVER returns to IDLE with no further outputs.
- Latency: prediction F -> E is 2 advances. Redirect is 0 cycles after the branch resolves in E, and the first correct fetch follows on the next clock.

Optional Feature:
BRANCH_STATS_EN.
- Defined: stat_branches increments on every en and stat_mispredicts increments on every mispredict. Both saturate at all-ones and clear on rst.
- Undefined: no counters are instantiated and both stat ports are tied to 0.

Decomposition:
- Package branch_pkg holds the following, shared with the predictor and fetch:
  - PC_W localparam.
  - resolve_state_t enum {IDLE, RECOVER}.
  - struct redirect_t {valid, pc}.
- One natural sub-module, branch_stats: the two saturating counters. It is instantiated only under BRANCH_STATS_EN.

Test Plan:
1. Correctly predicted branch: predict_f=1, is_branch_d=1, taken_e=1, no stalls -> en=1 for exactly 1 cycle two advances later, result=1, mispredict=0, redirect_valid=0.
2. Mispredict not-taken: predE=1, taken_e=0, PCE=0x0100 -> mispredict=flush_d=flush_e=redirect_valid=1, redirect_pc=0x0101. The next cycle is in RECOVER with en=0.
3. Mispredict taken with wrap: predE=0, taken_e=1, target_e=0x1234 -> redirect_pc=0x1234. Then with taken_e=0 and PCE=0x7FFF -> redirect_pc=0x0000.
4. Stall hold: branch in E, StallE=1 for 3 cycles then 0 -> en=0 during the stall, en=1 exactly once when StallE=0, and stat_branches increments by 1.
5. Squash of a D branch: mispredict in E while is_branch_d=1 -> that branch never produces en, and stat_branches increments by 1 total.
6. Reset in RECOVER: assert rst the cycle after a mispredict -> state=IDLE, all strobes 0, counters=0, and the next valid branch trains normally.
